// File: rtl/gate_sweep_checker_pkg.sv
// Shared definitions for the gate sweep checker: FSM encodings and sizing helper.
package gate_sweep_checker_pkg;

   // FSM state encodings
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_DRIVE  = 2'd1;
   localparam logic [1:0] ST_SAMPLE = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;

   typedef enum logic [1:0] {
      IDLE   = ST_IDLE,
      DRIVE  = ST_DRIVE,
      SAMPLE = ST_SAMPLE,
      DONE   = ST_DONE
   } state_e;

   // Settle counter width; a single-cycle settle still needs one bit.
   function automatic int cnt_width(input int settle);
      return (settle > 1) ? $clog2(settle) : 1;
   endfunction

endpackage

// File: rtl/gate_sweep_checker_if.sv
// Checker-side bundle: sweep control/results plus the gate drive/return pair.
interface gate_sweep_checker_if #(
   parameter int N_IN = 2
);
   logic            start;
   logic [N_IN-1:0] gate_in;
   logic            gate_out;
   logic            busy;
   logic            done;
   logic            pass;
   logic [N_IN:0]   err_count;
   logic [N_IN-1:0] first_fail;
   logic            fail_seen;

   // master: the checker itself
   modport master (
      input  start, gate_out,
      output gate_in, busy, done, pass, err_count, first_fail, fail_seen
   );

   // slave: the parent that requests sweeps and hosts the gate
   modport slave (
      output start, gate_out,
      input  gate_in, busy, done, pass, err_count, first_fail, fail_seen
   );
endinterface

// File: rtl/gate_settle_timer.sv
// Settle timer: counts cycles while enabled and flags the last settle cycle.
module gate_settle_timer
   import gate_sweep_checker_pkg::*;
#(
   parameter int SETTLE = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick_done
);
   localparam int            CW   = cnt_width(SETTLE);
   localparam logic [CW-1:0] LAST = CW'(SETTLE - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign tick_done = !clear && (cnt_q == LAST);

   // Hold at zero while cleared, count up, park on the last value.
   always_comb begin
      cnt_d = cnt_q;
      if (clear)
         cnt_d = '0;
      else if (!tick_done)
         cnt_d = cnt_q + CW'(1);
   end

   // Counter register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end
endmodule

// File: rtl/gate_sweep_checker.sv
// Exhaustive truth-table sweep of a single-output combinational gate.
module gate_sweep_checker
   import gate_sweep_checker_pkg::*;
#(
   parameter int                    N_IN   = 2,
   parameter logic [(1<<N_IN)-1:0]  EXPECT = 4'b1110,
   parameter int                    SETTLE = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   gate_sweep_checker_if.master bus
);
   localparam logic [N_IN-1:0] VEC_LAST = '1;

   state_e          state_q, state_d;
   logic [N_IN-1:0] vec_q, vec_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            pass_q, pass_d;
   logic [N_IN:0]   err_q, err_d;
   logic [N_IN-1:0] ff_q, ff_d;
   logic            fs_q, fs_d;
   logic            tick_done;
   logic            mismatch;
   logic            accept;

   // Timer only runs in DRIVE; every other state rearms it to zero.
   gate_settle_timer #(.SETTLE(SETTLE)) u_timer (
      .clk       (clk),
      .rst       (rst),
      .clear     (state_q != DRIVE),
      .tick_done (tick_done)
   );

   assign mismatch = (bus.gate_out != EXPECT[vec_q]);
   // The DONE exit edge counts as the first IDLE edge, so a held start
   // chains sweeps with no idle gap.
   assign accept   = bus.start && (state_q == IDLE || state_q == DONE);

   // Next-state and result-update logic
   always_comb begin
      state_d = state_q;
      vec_d   = vec_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      pass_d  = pass_q;
      err_d   = err_q;
      ff_d    = ff_q;
      fs_d    = fs_q;
      case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            vec_d  = '0;
         end
         DRIVE: begin
            if (tick_done) state_d = SAMPLE;
         end
         SAMPLE: begin
            if (mismatch) begin
               err_d = err_q + (N_IN+1)'(1);
               if (!fs_q) begin
                  ff_d = vec_q;
                  fs_d = 1'b1;
               end
            end
            if (vec_q == VEC_LAST) begin
               state_d = DONE;
               done_d  = 1'b1;
               pass_d  = (err_d == '0);
            end else begin
               vec_d   = vec_q + N_IN'(1);
               state_d = DRIVE;
            end
         end
         DONE: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            vec_d   = '0;
         end
         default: state_d = IDLE;
      endcase
      if (accept) begin
         state_d = DRIVE;
         vec_d   = '0;
         busy_d  = 1'b1;
         pass_d  = 1'b0;
         err_d   = '0;
         ff_d    = '0;
         fs_d    = 1'b0;
      end
   end

   // State and result registers; reset discards any partial sweep.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         vec_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         err_q   <= '0;
         ff_q    <= '0;
         fs_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         err_q   <= err_d;
         ff_q    <= ff_d;
         fs_q    <= fs_d;
      end
   end

   assign bus.gate_in    = vec_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.pass       = pass_q;
   assign bus.err_count  = err_q;
   assign bus.first_fail = ff_q;
   assign bus.fail_seen  = fs_q;
endmodule
